// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// Module   : cpu_pkg
// Purpose  : Shared constants and helpers for the P5 pipelined MIPS core:
//            instruction width, default reset PC, fetch FSM encoding and
//            a PC increment helper.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  // Fetch FSM encoding
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_ADDR = 2'd1;
  localparam logic [1:0]  ST_DATA = 2'd2;

  // PC arithmetic wraps modulo 2^32
  function automatic logic [31:0] pc_add(input logic [31:0] pc, input logic [31:0] step);
    return pc + step;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// Module   : fetch_skid_buf
// Purpose  : One-entry instruction/PC holding buffer. Captures a memory
//            response that arrives while the IF/ID register is stalled and
//            releases it when IF/ID is free again. Load has priority.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_load,
  input  logic               i_drain,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [31:0]        i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [31:0]        r_pc;

  // Capture a parked response; clear the flag once it has been handed on
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// Module   : fetch_unit
// Purpose  : IF stage plus IF/ID register of the P5 MIPS core. Issues
//            sequential fetches (one outstanding) on a req/ready/rvalid port,
//            parks a response while ID is stalled, and applies ID-stage
//            redirects with single delay-slot semantics.
// Options  : FETCH_PERF_EN adds perf_fetched / perf_stall counters.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc8
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  logic [1:0]         r_state;
  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_req_pc;
  logic               r_pend;
  logic [31:0]        r_tgt;
  logic               r_id_valid;
  logic [INSTR_W-1:0] r_id_instr;
  logic [31:0]        r_id_pc;
  logic [31:0]        r_id_pc8;

  logic               w_buf_valid;
  logic [INSTR_W-1:0] w_buf_instr;
  logic [31:0]        w_buf_pc;

  // A response only counts while a request is actually in flight; anything
  // else (e.g. one issued before a reset) is dropped.
  logic w_resp;
  logic w_load_id;
  logic w_buf_load;
  logic w_buf_drain;
  logic w_accept;
  logic w_redir;
  logic w_dslot_unissued;
  logic w_redir_pend;
  logic w_redir_now;
  logic w_pend_eff;
  logic [31:0] w_tgt_eff;

  assign w_resp      = imem_rvalid && (r_state == ST_DATA);
  assign w_load_id   = !stall || !r_id_valid;
  assign w_buf_load  = w_resp && !w_load_id;
  assign w_buf_drain = w_load_id && w_buf_valid;
  assign w_accept    = (r_state == ST_ADDR) && imem_ready;

  // If the delay slot has not been issued yet, the target must wait until it
  // is; otherwise the slot is already in flight or parked, so jump at once.
  assign w_redir          = r_id_valid && !stall && redirect;
  assign w_dslot_unissued = (r_fetch_pc == pc_add(r_id_pc, PC_STEP));
  assign w_redir_pend     = w_redir && w_dslot_unissued;
  assign w_redir_now      = w_redir && !w_dslot_unissued;
  // A redirect landing in the same cycle as the delay-slot accept must steer
  // the very next fetch PC.
  assign w_pend_eff       = r_pend || w_redir_pend;
  assign w_tgt_eff        = w_redir_pend ? redirect_pc : r_tgt;

  assign imem_req  = (r_state == ST_ADDR);
  assign imem_addr = r_fetch_pc;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_buf_load),
    .i_drain (w_buf_drain),
    .i_instr (imem_rdata),
    .i_pc    (r_req_pc),
    .o_valid (w_buf_valid),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );

  // Fetch FSM: issue when nothing is parked, chain straight on when a
  // response goes directly into IF/ID
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (!w_buf_valid) r_state <= ST_ADDR;
        ST_ADDR: if (imem_ready)   r_state <= ST_DATA;
        ST_DATA: if (imem_rvalid)  r_state <= w_load_id ? ST_ADDR : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Fetch PC, in-flight PC and deferred redirect target
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= PC_RESET;
      r_req_pc   <= PC_RESET;
      r_pend     <= 1'b0;
      r_tgt      <= '0;
    end else if (w_accept) begin
      r_fetch_pc <= w_pend_eff ? w_tgt_eff : pc_add(r_fetch_pc, PC_STEP);
      r_req_pc   <= r_fetch_pc;
      r_pend     <= 1'b0;
    end else begin
      if (w_redir_now) begin
        r_fetch_pc <= redirect_pc;
      end
      if (w_redir_pend) begin
        r_pend <= 1'b1;
        r_tgt  <= redirect_pc;
      end
    end
  end

  // IF/ID register: parked entry first, then a live response, else bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
      r_id_pc8   <= 32'd8;
    end else if (w_load_id) begin
      if (w_buf_valid) begin
        r_id_valid <= 1'b1;
        r_id_instr <= w_buf_instr;
        r_id_pc    <= w_buf_pc;
        r_id_pc8   <= pc_add(w_buf_pc, 32'd8);
      end else if (w_resp) begin
        r_id_valid <= 1'b1;
        r_id_instr <= imem_rdata;
        r_id_pc    <= r_req_pc;
        r_id_pc8   <= pc_add(r_req_pc, 32'd8);
      end else begin
        r_id_valid <= 1'b0;
      end
    end
  end

  assign id_valid = r_id_valid;
  assign id_instr = r_id_instr;
  assign id_pc    = r_id_pc;
  assign id_pc8   = r_id_pc8;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  // Accepted-response and stalled-ID cycle counters, free-running wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_resp)                r_perf_fetched <= r_perf_fetched + 32'd1;
      if (stall && r_id_valid)   r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

`default_nettype wire
